chan_scan_seq: RTL

Upstream sequencer for the 3-to-8 decoder stage. Steps a 3-bit channel code (sel_a = MSB, sel_c = LSB) through the channels enabled in an 8-bit mask. Each channel is held for a programmable dwell time. Supports single-pass and continuous scanning with start/stop control, so the decoder's one-hot outputs strobe the enabled channels in ascending order.

---
 rtl/chan_scan_pkg.sv | 12 +
 rtl/chan_next_sel.sv | 33 +++
 rtl/chan_scan_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/chan_scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
// The optional blanking cycle between channels is enabled with SCAN_BLANK_EN.
package chan_scan_pkg;
  localparam int NUM_CHAN = 8;
  localparam int CHAN_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } scan_state_e;
endpackage

// File: rtl/chan_next_sel.sv
// Combinational next-enabled-channel finder: lowest enabled channel above cur,
// otherwise wrap to the lowest enabled channel overall.
module chan_next_sel
  import chan_scan_pkg::*;
(
  input  logic [NUM_CHAN-1:0] mask,
  input  logic [CHAN_W-1:0]   cur,
  output logic [CHAN_W-1:0]   nxt,
  output logic                wrap
);
  logic [CHAN_W-1:0] above;
  logic [CHAN_W-1:0] lowest;
  logic              hit;

  // Descending scan so the last match written is the lowest qualifying bit.
  always_comb begin
    above  = '0;
    lowest = '0;
    hit    = 1'b0;
    for (int i = NUM_CHAN-1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = CHAN_W'(i);
        if (i > int'(cur)) begin
          above = CHAN_W'(i);
          hit   = 1'b1;
        end
      end
    end
  end

  assign wrap = ~hit;
  assign nxt  = hit ? above : lowest;
endmodule

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer feeding the 3-to-8 decoder; dwells on each enabled
// channel in ascending order. SCAN_BLANK_EN inserts a blank cycle per change.
module chan_scan_seq
  import chan_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                mode_cont,
  input  logic [NUM_CHAN-1:0] chan_mask,
  input  logic [DWELL_W-1:0]  dwell,
  output logic                sel_a,
  output logic                sel_b,
  output logic                sel_c,
  output logic                sel_valid,
  output logic                busy,
  output logic                scan_done
);
  scan_state_e         state;
  logic [NUM_CHAN-1:0] mask_r;
  logic [DWELL_W-1:0]  dwell_r;
  logic                cont_r;
  logic [DWELL_W-1:0]  cnt;
  logic [CHAN_W-1:0]   cur_ch;
  logic [CHAN_W-1:0]   sel_r;

  logic [NUM_CHAN-1:0] srch_mask;
  logic [CHAN_W-1:0]   srch_cur;
  logic [CHAN_W-1:0]   nxt_ch;
  logic                nxt_wrap;
  logic [DWELL_W-1:0]  dwell_eff;
  logic                go;

  // One finder serves both searches: from IDLE, cur=7 always wraps to the
  // lowest channel of the incoming mask.
  assign srch_mask = (state == IDLE) ? chan_mask : mask_r;
  assign srch_cur  = (state == IDLE) ? CHAN_W'(NUM_CHAN-1) : cur_ch;

  chan_next_sel u_next (
    .mask (srch_mask),
    .cur  (srch_cur),
    .nxt  (nxt_ch),
    .wrap (nxt_wrap)
  );

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign go        = start && !stop && (chan_mask != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_r    <= '0;
      dwell_r   <= '0;
      cont_r    <= 1'b0;
      cnt       <= '0;
      cur_ch    <= '0;
      sel_r     <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          sel_r     <= '0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
          if (go) begin
            state     <= DWELL;
            mask_r    <= chan_mask;
            dwell_r   <= dwell_eff;
            cont_r    <= mode_cont;
            cnt       <= dwell_eff - DWELL_W'(1);
            cur_ch    <= nxt_ch;
            sel_r     <= nxt_ch;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        DWELL: begin
          if (stop) begin
            state     <= IDLE;
            sel_r     <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (nxt_wrap && !cont_r) begin
            state     <= IDLE;
            sel_r     <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b1;
          end else begin
            cur_ch    <= nxt_ch;
            scan_done <= nxt_wrap;
`ifdef SCAN_BLANK_EN
            state     <= BLANK;
            sel_r     <= '0;
            sel_valid <= 1'b0;
`else
            cnt       <= dwell_r - DWELL_W'(1);
            sel_r     <= nxt_ch;
`endif
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (stop) begin
            state     <= IDLE;
            sel_r     <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end else begin
            state     <= DWELL;
            cnt       <= dwell_r - DWELL_W'(1);
            sel_r     <= cur_ch;
            sel_valid <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          sel_r     <= '0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign sel_a = sel_r[2];
  assign sel_b = sel_r[1];
  assign sel_c = sel_r[0];
endmodule
